// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bist_pkg
// Description : Shared types and defaults for the ALU self-test controller:
//               FSM state encoding, default LFSR/MISR constants and the
//               response-folding helper used by the signature register.
// Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

    // Controller states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEED = 3'd1,
        RUN  = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } bist_state_e;

    // Default pattern generator: x^11 + x^9 + 1, seeded with 1
    localparam logic [10:0] c_LFSR_TAPS_DEFAULT = 11'h500;
    localparam logic [10:0] c_LFSR_SEED_DEFAULT = 11'h001;

    // Default signature register: x^8 + x^4 + x^3 + x^2 + 1 (x^8 implicit)
    localparam logic [7:0]  c_MISR_POLY_DEFAULT = 8'h1D;
    localparam logic [7:0]  c_MISR_SEED_DEFAULT = 8'h00;

    // Widest response vector the fold helper accepts
    localparam int          c_FOLD_MAX_W        = 32;

    // XOR-fold the low in_w bits of r into out_w-bit chunks. Bit i of the
    // response lands on bit (i mod out_w) of the result, so a short final
    // chunk is implicitly zero-extended. Bits at or above out_w are zero.
    function automatic logic [c_FOLD_MAX_W-1:0] fold_xor(
        input logic [c_FOLD_MAX_W-1:0] r,
        input int                      in_w,
        input int                      out_w
    );
        logic [c_FOLD_MAX_W-1:0] f;
        int                      k;
        f = '0;
        k = 0;
        for (int i = 0; i < c_FOLD_MAX_W; i++) begin
            if (i < in_w) begin
                f[k] = f[k] ^ r[i];
                k    = (k == out_w - 1) ? 0 : k + 1;
            end
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ============================================================================
// Module      : bist_misr
// Description : Multiple-input signature register. Shifts left with
//               polynomial feedback from the MSB and XORs in the folded
//               response each enabled cycle; load restores the seed.
//               IN_W must not exceed bist_pkg::c_FOLD_MAX_W.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_misr
    import bist_pkg::*;
#(
    parameter int                MISR_W    = 8,
    parameter logic [MISR_W-1:0] MISR_POLY = c_MISR_POLY_DEFAULT,
    parameter logic [MISR_W-1:0] MISR_SEED = c_MISR_SEED_DEFAULT,
    parameter int                IN_W      = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [IN_W-1:0]   din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] r_sig;
    logic [MISR_W-1:0] w_fold;
    logic [MISR_W-1:0] w_shift;

    assign w_fold  = MISR_W'(fold_xor(c_FOLD_MAX_W'(din), IN_W, MISR_W));
    assign w_shift = {r_sig[MISR_W-2:0], 1'b0} ^ (r_sig[MISR_W-1] ? MISR_POLY : '0);

    // Signature register: reset/load to seed, compact one response when enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sig <= MISR_SEED;
        end else if (load) begin
            r_sig <= MISR_SEED;
        end else if (en) begin
            r_sig <= w_shift ^ w_fold;
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/bist_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bist_alu_ctrl
// Description : ALU self-test controller. An LFSR drives operand/select
//               patterns into the combinational ALU, a MISR compacts
//               NUM_PATTERNS responses, and the final signature is compared
//               with a run-time golden value behind a start/busy/done
//               handshake.
//               Optional macro BIST_ALU_CTRL_CONTINUOUS_EN adds a
//               'continuous' input: back-to-back runs with a sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_alu_ctrl
    import bist_pkg::*;
#(
    parameter int                          DATA_W       = 4,
    parameter int                          SEL_W        = 3,
    parameter int                          MISR_W       = 8,
    parameter int                          NUM_PATTERNS = 255,
    parameter logic [2*DATA_W+SEL_W-1:0]   LFSR_TAPS    = c_LFSR_TAPS_DEFAULT,
    parameter logic [2*DATA_W+SEL_W-1:0]   LFSR_SEED    = c_LFSR_SEED_DEFAULT,
    parameter logic [MISR_W-1:0]           MISR_POLY    = c_MISR_POLY_DEFAULT,
    parameter logic [MISR_W-1:0]           MISR_SEED    = c_MISR_SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef BIST_ALU_CTRL_CONTINUOUS_EN
    input  logic                  continuous,
`endif
    input  logic [MISR_W-1:0]     golden_sig,
    output logic [DATA_W-1:0]     pat_a,
    output logic [DATA_W-1:0]     pat_b,
    output logic [SEL_W-1:0]      pat_sel,
    input  logic [2*DATA_W-1:0]   dut_out,
    input  logic                  dut_zero,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fault_detected,
    output logic [MISR_W-1:0]     signature
);

    localparam int PAT_W = 2*DATA_W + SEL_W;
    localparam int RES_W = 2*DATA_W + 1;
    localparam int CNT_W = 16;

    bist_state_e        r_state;
    bist_state_e        w_state_nxt;
    logic [PAT_W-1:0]   r_lfsr;
    logic [PAT_W-1:0]   w_lfsr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pass;
    logic               r_fault;
    logic               w_last;
    logic               w_match;
    logic [MISR_W-1:0]  w_sig;
    logic [RES_W-1:0]   w_resp;

    assign w_last  = (r_cnt == CNT_W'(NUM_PATTERNS - 1));
    assign w_match = (w_sig == golden_sig);
    assign w_resp  = {dut_zero, dut_out};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only honoured in IDLE and DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = SEED;
            SEED: w_state_nxt = RUN;
            RUN:  if (w_last) w_state_nxt = CMP;
            CMP:  w_state_nxt = DONE;
            DONE: begin
`ifdef BIST_ALU_CTRL_CONTINUOUS_EN
                if (start || continuous) w_state_nxt = SEED;
`else
                if (start) w_state_nxt = SEED;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // LFSR step; an all-zero state would stall, so reseed instead
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (r_lfsr == '0) begin
            w_lfsr_nxt = LFSR_SEED;
        end else begin
            w_lfsr_nxt = {r_lfsr[PAT_W-2:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    // Pattern generator, pattern counter and verdict registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr  <= LFSR_SEED;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                SEED: begin
                    r_lfsr <= LFSR_SEED;
                    r_cnt  <= '0;
                    r_pass <= 1'b0;
`ifndef BIST_ALU_CTRL_CONTINUOUS_EN
                    r_fault <= 1'b0;
`endif
                end
                RUN: begin
                    r_lfsr <= w_lfsr_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                end
                CMP: begin
                    r_pass <= w_match;
`ifdef BIST_ALU_CTRL_CONTINUOUS_EN
                    // Fault accumulates across back-to-back runs
                    r_fault <= r_fault | ~w_match;
`else
                    r_fault <= ~w_match;
`endif
                end
`ifdef BIST_ALU_CTRL_CONTINUOUS_EN
                IDLE, DONE: begin
                    // A fresh single-shot start drops any accumulated fault
                    if (start && !continuous) r_fault <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    bist_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY),
        .MISR_SEED (MISR_SEED),
        .IN_W      (RES_W)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (r_state == SEED),
        .en    (r_state == RUN),
        .din   (w_resp),
        .sig   (w_sig)
    );

    assign pat_a          = r_lfsr[PAT_W-1 -: DATA_W];
    assign pat_b          = r_lfsr[PAT_W-1-DATA_W -: DATA_W];
    assign pat_sel        = r_lfsr[SEL_W-1:0];
    assign busy           = (r_state == SEED) || (r_state == RUN) || (r_state == CMP);
    assign done           = (r_state == DONE);
    assign pass           = r_pass;
    assign fault_detected = r_fault;
    assign signature      = w_sig;

endmodule
`default_nettype wire
